// File: rtl/ps2_game_cmd.sv
// ps2_game_cmd
//
// Turns the raw PS/2 byte stream from the keyboard controller into one-cycle Tetris game
// commands for the VGA game controller. The block:
//   - parses make, break and extended (E0) sequences,
//   - drops the keyboard's own typematic repeats,
//   - generates its own auto-repeat for the movement keys (LEFT, RIGHT, DOWN),
//   - tracks a pause toggle.
//
// Parameters:
//   REPEAT_DELAY   - cycles from a movement make to its first auto-repeat
//   REPEAT_PERIOD  - cycles between later auto-repeats
//   PREFIX_TIMEOUT - idle cycles a prefix state waits for its next byte before abandoning it
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous, active-high reset
//   key_data    in   PS/2 byte, valid while key_pressed is high
//   key_pressed in   one-cycle strobe per received byte
//   cmd_valid   out  one-cycle command pulse
//   cmd         out  command code: 1 LEFT, 2 RIGHT, 3 DOWN, 4 ROTATE, 5 DROP, 6 PAUSE;
//                    holds its last value while cmd_valid is low
//   held        out  key levels: bit 0 left, 1 right, 2 down, 3 rotate
//   paused      out  pause state, toggled by every PAUSE command

module ps2_game_cmd #(
    parameter int unsigned REPEAT_DELAY   = 12500000,
    parameter int unsigned REPEAT_PERIOD  = 2500000,
    parameter int unsigned PREFIX_TIMEOUT = 250000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] key_data,
    input  logic       key_pressed,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [3:0] held,
    output logic       paused
);

    // Counter widths cover the largest value each counter must hold.
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RptW   = ($clog2(RptMax + 1) < 1) ? 1 : $clog2(RptMax + 1);
    localparam int unsigned ToW    = ($clog2(PREFIX_TIMEOUT + 1) < 1) ? 1
                                                                      : $clog2(PREFIX_TIMEOUT + 1);

    localparam logic [7:0] CodeExt    = 8'hE0;
    localparam logic [7:0] CodeBrk    = 8'hF0;
    localparam logic [7:0] CodeLeft   = 8'h6B;
    localparam logic [7:0] CodeRight  = 8'h74;
    localparam logic [7:0] CodeDown   = 8'h72;
    localparam logic [7:0] CodeRotate = 8'h75;
    localparam logic [7:0] CodeDrop   = 8'h29;
    localparam logic [7:0] CodePause  = 8'h4D;

    // Key indices; the command code is always index + 1.
    localparam logic [2:0] KeyLeft   = 3'd0;
    localparam logic [2:0] KeyRight  = 3'd1;
    localparam logic [2:0] KeyDown   = 3'd2;
    localparam logic [2:0] KeyRotate = 3'd3;
    localparam logic [2:0] KeyDrop   = 3'd4;
    localparam logic [2:0] KeyPause  = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } state_e;

    state_e            state_q;
    logic [ToW-1:0]    tout_q;
    logic [5:0]        flags_q;     // held flags for all six keys
    logic              paused_q;
    logic              cmd_valid_q;
    logic [2:0]        cmd_q;
    logic              rpt_act_q;
    logic [1:0]        rpt_key_q;
    logic [RptW-1:0]   rpt_cnt_q;

    // ------------------------------------------------------------------
    // Byte classification for the current strobe
    // ------------------------------------------------------------------
    logic       ev_make;
    logic       ev_break;
    logic       ev_ext;
    logic       key_hit;
    logic [2:0] key_idx;
    logic [5:0] key_oh;

    always_comb begin
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_ext   = 1'b0;
        if (key_pressed) begin
            unique case (state_q)
                StIdle: begin
                    ev_make = (key_data != CodeExt) && (key_data != CodeBrk);
                end
                StExt: begin
                    ev_make = (key_data != CodeBrk);
                    ev_ext  = 1'b1;
                end
                StBrk: begin
                    ev_break = 1'b1;
                end
                StExtBrk: begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Map the byte to a key; the same byte means different keys with and without E0.
    always_comb begin
        key_hit = 1'b0;
        key_idx = KeyLeft;
        if (ev_ext) begin
            unique case (key_data)
                CodeLeft:   begin key_hit = 1'b1; key_idx = KeyLeft;   end
                CodeRight:  begin key_hit = 1'b1; key_idx = KeyRight;  end
                CodeDown:   begin key_hit = 1'b1; key_idx = KeyDown;   end
                CodeRotate: begin key_hit = 1'b1; key_idx = KeyRotate; end
                default: ;
            endcase
        end else begin
            unique case (key_data)
                CodeDrop:  begin key_hit = 1'b1; key_idx = KeyDrop;  end
                CodePause: begin key_hit = 1'b1; key_idx = KeyPause; end
                default: ;
            endcase
        end
    end

    always_comb begin
        key_oh = 6'b0;
        if (key_hit) begin
            key_oh = 6'b1 << key_idx;
        end
    end

    // ------------------------------------------------------------------
    // Command decisions
    // ------------------------------------------------------------------
    logic       key_is_move;
    logic       make_new;
    logic       brk_hit;
    logic       pcmd_emit;
    logic [2:0] pcmd_code;
    logic       brk_active;
    logic       rpt_expire;
    logic       rpt_fire;
    logic [2:0] rpt_code;

    always_comb begin
        key_is_move = |key_oh[2:0];
        // A make of a key whose flag is already set is a typematic duplicate.
        make_new    = ev_make && key_hit && ((flags_q & key_oh) == 6'b0);
        brk_hit     = ev_break && key_hit;
        // While paused only PAUSE itself reaches the game.
        pcmd_emit   = make_new && (!paused_q || key_oh[KeyPause]);
        pcmd_code   = key_idx + 3'd1;
        brk_active  = brk_hit && key_is_move && rpt_act_q && (rpt_key_q == key_idx[1:0]);
        // A count of 1 expires this cycle; a count of 0 is an expiry that lost to a
        // parser command and is still pending.
        rpt_expire  = rpt_act_q && !paused_q && (rpt_cnt_q <= RptW'(1));
        rpt_fire    = rpt_expire && !pcmd_emit;
        rpt_code    = {1'b0, rpt_key_q} + 3'd1;
    end

    // ------------------------------------------------------------------
    // Parser FSM, key flags, repeat engine and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            tout_q      <= '0;
            flags_q     <= 6'b0;
            paused_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= 3'd0;
            rpt_act_q   <= 1'b0;
            rpt_key_q   <= 2'd0;
            rpt_cnt_q   <= '0;
        end else begin
            // Parser state and prefix timeout
            if (key_pressed) begin
                tout_q <= '0;
                unique case (state_q)
                    StIdle: begin
                        if (key_data == CodeExt) begin
                            state_q <= StExt;
                        end else if (key_data == CodeBrk) begin
                            state_q <= StBrk;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StExt: begin
                        state_q <= (key_data == CodeBrk) ? StExtBrk : StIdle;
                    end
                    StBrk, StExtBrk: begin
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (state_q != StIdle) begin
                if (tout_q >= ToW'(PREFIX_TIMEOUT - 1)) begin
                    state_q <= StIdle;
                    tout_q  <= '0;
                end else begin
                    tout_q <= tout_q + ToW'(1);
                end
            end

            // Key flags
            if (make_new) begin
                flags_q <= flags_q | key_oh;
            end else if (brk_hit) begin
                flags_q <= flags_q & ~key_oh;
            end

            if (pcmd_emit && key_oh[KeyPause]) begin
                paused_q <= ~paused_q;
            end

            // Repeat slot: a fresh movement make always takes it over.
            if (make_new && key_is_move) begin
                rpt_act_q <= 1'b1;
                rpt_key_q <= key_idx[1:0];
                rpt_cnt_q <= RptW'(REPEAT_DELAY);
            end else if (brk_active) begin
                rpt_act_q <= 1'b0;
                rpt_cnt_q <= '0;
            end else if (rpt_fire) begin
                rpt_cnt_q <= RptW'(REPEAT_PERIOD);
            end else if (rpt_expire) begin
                rpt_cnt_q <= '0;
            end else if (rpt_act_q && !paused_q) begin
                rpt_cnt_q <= rpt_cnt_q - RptW'(1);
            end

            // Outputs: parser command beats a repeat expiry in the same cycle.
            cmd_valid_q <= 1'b0;
            if (pcmd_emit) begin
                cmd_valid_q <= 1'b1;
                cmd_q       <= pcmd_code;
            end else if (rpt_fire) begin
                cmd_valid_q <= 1'b1;
                cmd_q       <= rpt_code;
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign held      = flags_q[3:0];
    assign paused    = paused_q;

endmodule

// File: doc/ps2_game_cmd.md
# ps2_game_cmd

Converts the raw PS/2 byte stream from the keyboard controller into one-cycle Tetris game commands for the VGA game controller. It sits between the PS/2 interface, which supplies `key_data` and the `key_pressed` strobe, and the game logic in the VGA controller. The block does the following:
- Parses make, break and extended (E0) codes.
- Drops the keyboard's own typematic repeats.
- Generates its own auto-repeat for movement keys.
- Tracks a pause toggle.

## Interface
Parameters:
- `REPEAT_DELAY`, default 12500000: cycles from the first press of a movement key to its first auto-repeat (250 ms at 50 MHz).
- `REPEAT_PERIOD`, default 2500000: cycles between later auto-repeats (50 ms).
- `PREFIX_TIMEOUT`, default 250000: cycles a prefix state may wait for its next byte before it is abandoned.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high reset.
- `key_data` in 8: PS/2 byte, valid while `key_pressed` is high.
- `key_pressed` in 1: one-cycle strobe, one per received byte.
- `cmd_valid` out 1: one-cycle pulse; a command is present.
- `cmd` out 3: command code. 1 = LEFT, 2 = RIGHT, 3 = DOWN, 4 = ROTATE, 5 = DROP, 6 = PAUSE. Holds its last value when `cmd_valid` is low.
- `held` out 4: level per key, bit 0 = left, 1 = right, 2 = down, 3 = rotate.
- `paused` out 1: pause state, toggled by each PAUSE command.

## Operation
Key map:
- E0 6B → LEFT
- E0 74 → RIGHT
- E0 72 → DOWN
- E0 75 → ROTATE
- 29 (space) → DROP
- 4D (P) → PAUSE

Any other code, extended or not, is consumed and ignored. It does not change `held` and does not emit a command.

Parser FSM states: IDLE, EXT, BRK, EXT_BRK.
- In IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte is a plain make; stay in IDLE.
- In EXT:
  - F0 → EXT_BRK.
  - Any other byte is an extended make → IDLE.
- In BRK: any byte is a plain break → IDLE.
- In EXT_BRK: any byte is an extended break → IDLE.
- In any prefix state, if no `key_pressed` arrives for `PREFIX_TIMEOUT` cycles → IDLE, and the partial sequence is discarded.

Make handling:
- If the key's `held` bit (or internal held flag, for DROP and PAUSE) is already set, the make is a typematic duplicate: emit nothing.
- Otherwise set the flag and emit the command.
- A make of LEFT, RIGHT or DOWN also makes that key the active repeat key and loads the repeat counter with `REPEAT_DELAY`.

Break handling:
- Clear the key's flag; emit nothing.
- If the key is the active repeat key, clear the active repeat key.

Auto-repeat:
- Only the active key repeats; at most one key repeats at a time.
- While the active key is set, the counter decrements once per cycle.
- When it reaches 0, emit the active key's command and reload the counter with `REPEAT_PERIOD`.
- A newly pressed movement key takes over the active slot.
- Releasing the active key does not hand repeating back to another movement key that is still held.

Pause:
- A PAUSE command toggles `paused`.
- While `paused` = 1:
  - LEFT, RIGHT, DOWN, ROTATE and DROP are not emitted, but `held` still tracks key state.
  - The repeat counter is frozen.
  - PAUSE is still emitted.

Conflict rule: if a parser command and a repeat expiry fall in the same cycle, the parser command wins. The repeat counter stays at 0 and fires on the next cycle, unless the parser command reloaded the counter.

## Timing
Reset values:
- State: IDLE.
- `cmd_valid` = 0, `cmd` = 0, `held` = 0, `paused` = 0.
- DROP and PAUSE held flags cleared.
- Active repeat key: none. Repeat counter: 0. Timeout counter: 0.

Reset has priority over every other event, including reset in the middle of a sequence: a pending prefix or repeat is discarded and no command is emitted.

Latency:
- `key_pressed` with the final byte of a make at cycle n → `cmd_valid` high in cycle n+1 only.
- `held` updates in cycle n+1.

Repeat timing, for a movement make completing at cycle n:
- First repeat pulse at cycle n+1+`REPEAT_DELAY`.
- Later pulses every `REPEAT_PERIOD` cycles.

`cmd_valid` is never high for two consecutive cycles from the same event. Counter widths are sized to hold the largest parameter.

## Test plan
The bench uses `REPEAT_DELAY` = 10, `REPEAT_PERIOD` = 4, `PREFIX_TIMEOUT` = 20.

1. Send E0, 6B → a single pulse with `cmd` = 1 one cycle after the 6B strobe, and `held` = 0001. Then send E0, F0, 6B → `held` = 0000 and no pulse.
2. Hold RIGHT (E0 74) with no further bytes → pulses at +1, +11, +15 and +19 cycles after the 74 strobe. A later E0 F0 74 → no further pulses.
3. With LEFT held, inject typematic E0 6B three times → no extra pulses, and the repeat cadence is unchanged.
4. Send 4D, F0 4D → `cmd` = 6 and `paused` = 1. Then E0 75 → no pulse, but `held[3]` = 1. Then 4D, F0 4D → `paused` = 0.
5. Send E0, wait 25 cycles, send 6B → treated as a plain make of an unmapped code: no pulse, `held` = 0000. Unknown code 1C → ignored.
6. Assert `reset` in the cycle between E0 and 72 → all outputs return to their reset values. The following 72 is treated as a plain, unmapped make and produces no command.
